mem_arbiter: RTL

- Shares one single-port data memory between two requesters.
- Port 0 is the processor data port (address, write_data, mem_write, read_data); port 1 is a peripheral master such as a program loader or display fetch.
- Arbitration is round-robin with a bounded burst length.
- Read data returns after a fixed memory latency and is tagged back to the requester that issued the read.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of one single-port data memory: round-robin with a bounded
// burst, Mealy grants, and a fixed-latency read-return pipe tagged with the requester id.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [3:0] BURST_CNT = 4'(BURST);

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_beat_cnt, w_beat_nxt, w_beat_inc;
  logic              r_rr_ptr, w_rr_nxt;
  logic [RD_LAT-1:0] r_rd_vld, r_rd_id;
  logic              w_gnt0, w_gnt1;
  logic              w_rd_push;

  assign w_beat_inc = (r_beat_cnt >= BURST_CNT) ? BURST_CNT : r_beat_cnt + 4'd1;

  // NOTE: every variable gets a default at the top so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_rr_nxt    = r_rr_ptr;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_req && (!m1_req || !r_rr_ptr)) begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_beat_nxt  = 4'd1;
        end else if (m1_req) begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_beat_nxt  = 4'd1;
        end
      end
      OWN0: begin
        if (m0_req && (r_beat_cnt < BURST_CNT || !m1_req)) begin
          w_gnt0     = 1'b1;
          w_beat_nxt = w_beat_inc;
        end else if (m1_req) begin
          w_gnt1      = 1'b1;
          w_state_nxt = OWN1;
          w_beat_nxt  = 4'd1;
        end else begin
          w_state_nxt = IDLE;
          w_beat_nxt  = 4'd0;
          w_rr_nxt    = 1'b1;
        end
      end
      OWN1: begin
        if (m1_req && (r_beat_cnt < BURST_CNT || !m0_req)) begin
          w_gnt1     = 1'b1;
          w_beat_nxt = w_beat_inc;
        end else if (m0_req) begin
          w_gnt0      = 1'b1;
          w_state_nxt = OWN0;
          w_beat_nxt  = 4'd1;
        end else begin
          w_state_nxt = IDLE;
          w_beat_nxt  = 4'd0;
          w_rr_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Grants are combinational, so they must be masked while reset is held.
    if (!rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat_cnt <= 4'd0;
      r_rr_ptr   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_rr_ptr   <= w_rr_nxt;
    end
  end

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_we    = (w_gnt0 & m0_we) | (w_gnt1 & m1_we);
  assign mem_addr  = w_gnt0 ? m0_addr  : (w_gnt1 ? m1_addr  : '0);
  assign mem_wdata = w_gnt0 ? m0_wdata : (w_gnt1 ? m1_wdata : '0);
  assign w_rd_push = (w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we);

  // Read-return pipe: the stage at RD_LAT-1 lines up with mem_rdata for that read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_vld <= '0;
      r_rd_id  <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_id[i]  <= r_rd_id[i-1];
      end
      r_rd_vld[0] <= w_rd_push;
      r_rd_id[0]  <= w_gnt1;
    end
  end

  assign m0_rvalid = r_rd_vld[RD_LAT-1] & ~r_rd_id[RD_LAT-1];
  assign m1_rvalid = r_rd_vld[RD_LAT-1] &  r_rd_id[RD_LAT-1];
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
